multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mc_ctrl_pkg.sv | 142 ++++++++++++++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/multicycle_ctrl.sv | 148 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state, opcode, select and trap-cause encodings for the multicycle controller
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_BEQ      = 4'd11,
    S_AUIPC    = 4'd12,
    S_LUI      = 4'd13,
    S_HALT     = 4'd14,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       branch;
    logic       pcupdate;
    logic       regwrite;
    logic       memwrite;
    logic       adrsrc;
    logic       fetch_gate;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       trap;
    logic       halted;
  } ctrl_t;

  // fetch_gate marks FETCH, where pcupdate/irwrite follow mem_ready combinationally.
  function automatic ctrl_t ctrl_decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.fetch_gate = 1'b1;
        c.resultsrc  = RES_ALURES;
        c.alusrcb    = SRCB_FOUR;
      end
      S_DECODE: begin
        c.alusrca = SRCA_OLDPC;
        c.alusrcb = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adrsrc  = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite  = 1'b1;
        c.resultsrc = RES_DATA;
      end
      S_MEMWRITE: begin
        c.mem_req  = 1'b1;
        c.memwrite = 1'b1;
        c.adrsrc   = 1'b1;
      end
      S_EXECR: begin
        c.alusrca = SRCA_RS1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: c.regwrite = 1'b1;
      S_JAL: begin
        c.pcupdate = 1'b1;
        c.alusrca  = SRCA_OLDPC;
        c.alusrcb  = SRCB_FOUR;
      end
      S_JALR: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_IMM;
      end
      S_BEQ: begin
        c.branch  = 1'b1;
        c.alusrca = SRCA_RS1;
        c.aluop   = ALUOP_SUB;
      end
      S_AUIPC: begin
        c.alusrca = SRCA_OLDPC;
        c.alusrcb = SRCB_IMM;
      end
      S_LUI: begin
        c.regwrite  = 1'b1;
        c.resultsrc = RES_IMM;
      end
      S_HALT: c.halted = 1'b1;
      S_TRAP: c.trap = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - consecutive memory-wait cycle counter with expiry at TIMEOUT_MAX
module mem_wait_timer #(
  parameter int TIMEOUT_MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturates at LIMIT; the controller leaves the waiting state once expired fires.
  always_comb begin
    cnt_d = cnt_q;
    if (!req || ready) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = req & ~ready & (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM for a multicycle RV32I-style datapath
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             branch,
  output logic             pcupdate,
  output logic             regwrite,
  output logic             memwrite,
  output logic             irwrite,
  output logic             adrsrc,
  output logic [1:0]       resultsrc,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic             halted,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  import mc_ctrl_pkg::*;

  state_e           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] instret_q;
  logic             expired;
  logic             retire;
  logic             fetch_ok;

  mem_wait_timer #(
    .TIMEOUT_MAX(TIMEOUT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .req    (ctrl_q.mem_req),
    .ready  (mem_ready),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    cause_d = CAUSE_NONE;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (op)
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_AUIPC:          state_d = S_AUIPC;
          OP_LUI:            state_d = S_LUI;
          OP_SYSTEM:         state_d = S_HALT;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB, S_ALUWB, S_BEQ, S_LUI: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_AUIPC: state_d = S_ALUWB;
      S_JALR: state_d = S_JAL;
      S_HALT: state_d = S_HALT;
      S_TRAP: begin
        state_d = S_TRAP;
        cause_d = cause_q;
      end
      default: begin
        state_d = S_TRAP;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
  end

  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ, S_LUI});

  // Outputs are decoded from the next state so they register together with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cause_q   <= CAUSE_NONE;
      ctrl_q    <= ctrl_decode(S_FETCH);
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      ctrl_q  <= ctrl_decode(state_d);
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign fetch_ok   = ctrl_q.fetch_gate & mem_ready & ~rst;

  assign mem_req    = ctrl_q.mem_req;
  assign branch     = ctrl_q.branch;
  assign pcupdate   = ctrl_q.pcupdate | fetch_ok;
  assign regwrite   = ctrl_q.regwrite;
  assign memwrite   = ctrl_q.memwrite;
  assign irwrite    = fetch_ok;
  assign adrsrc     = ctrl_q.adrsrc;
  assign resultsrc  = ctrl_q.resultsrc;
  assign alusrca    = ctrl_q.alusrca;
  assign alusrcb    = ctrl_q.alusrcb;
  assign aluop      = ctrl_q.aluop;
  assign trap       = ctrl_q.trap;
  assign halted     = ctrl_q.halted;
  assign trap_cause = cause_q;
  assign state_o    = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven and directed checks for multicycle_ctrl
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic       mem_ready = 1'b0;
  logic       mem_req, branch, pcupdate, regwrite, memwrite, irwrite, adrsrc;
  logic [1:0] resultsrc, alusrca, alusrcb, aluop, trap_cause;
  logic       trap, halted;
  logic [3:0] state_o;
  logic [3:0] instret;

  multicycle_ctrl #(.CNT_W(4), .TIMEOUT_MAX(4)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .branch(branch), .pcupdate(pcupdate), .regwrite(regwrite),
    .memwrite(memwrite), .irwrite(irwrite), .adrsrc(adrsrc), .resultsrc(resultsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .trap(trap),
    .trap_cause(trap_cause), .halted(halted), .state_o(state_o), .instret(instret)
  );

  always #5 clk = ~clk;

  wire [18:0] outs = {mem_req, branch, pcupdate, regwrite, memwrite, irwrite, adrsrc,
                      resultsrc, alusrca, alusrcb, aluop, trap, trap_cause, halted};

  localparam logic [6:0] R  = 7'b0110011, I  = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JR = 7'b1100111;
  localparam logic [6:0] AU = 7'b0010111, LU = 7'b0110111, SY = 7'b1110011;
  localparam logic [6:0] IL = 7'b0000000;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       rdy;
    logic [3:0] st;
    logic [18:0] outs;
    logic [3:0] ret;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [18:0] O_FR, O_FN, O_DEC, O_MAD, O_MRD, O_MWB, O_MWR, O_EXR, O_EXI;
  logic [18:0] O_AWB, O_JAL, O_JLR, O_BEQ, O_AUI, O_LUI, O_HLT, O_TI, O_TT;

  function automatic logic [18:0] mk(input logic mr, br, pc, rw, mw, ir, ad,
                                     input logic [1:0] rs, sa, sb, ao,
                                     input logic tr, input logic [1:0] tc, input logic h);
    return {mr, br, pc, rw, mw, ir, ad, rs, sa, sb, ao, tr, tc, h};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [6:0] o, input logic rd);
    @(negedge clk);
    rst = r;
    op = o;
    mem_ready = rd;
    #1;
  endtask

  task automatic add(input logic r, input logic [6:0] o, input logic rd,
                     input logic [3:0] st, input logic [18:0] ou, input logic [3:0] rt);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = rd; v.st = st; v.outs = ou; v.ret = rt;
    vecs.push_back(v);
  endtask

  initial begin
    int fc;
    O_FR  = mk(1,0,1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00, 0,2'b00,0);
    O_FN  = mk(1,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0,2'b00,0);
    O_DEC = mk(0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0,2'b00,0);
    O_MAD = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,2'b00,0);
    O_MRD = mk(1,0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,2'b00,0);
    O_MWB = mk(0,0,0,1,0,0,0, 2'b01,2'b00,2'b00,2'b00, 0,2'b00,0);
    O_MWR = mk(1,0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00, 0,2'b00,0);
    O_EXR = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0,2'b00,0);
    O_EXI = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10, 0,2'b00,0);
    O_AWB = mk(0,0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,2'b00,0);
    O_JAL = mk(0,0,1,0,0,0,0, 2'b00,2'b01,2'b10,2'b00, 0,2'b00,0);
    O_JLR = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,2'b00,0);
    O_BEQ = mk(0,1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b01, 0,2'b00,0);
    O_AUI = mk(0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0,2'b00,0);
    O_LUI = mk(0,0,0,1,0,0,0, 2'b11,2'b00,2'b00,2'b00, 0,2'b00,0);
    O_HLT = mk(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,2'b00,1);
    O_TI  = mk(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,2'b01,0);
    O_TT  = mk(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,2'b10,0);

    // R-type
    add(1,R,1,S_FETCH,O_FN,0);   add(0,R,1,S_FETCH,O_FR,0);
    add(0,R,1,S_DECODE,O_DEC,0); add(0,R,1,S_EXECR,O_EXR,0);
    add(0,R,1,S_ALUWB,O_AWB,0);
    // load with three wait cycles
    add(0,LD,1,S_FETCH,O_FR,1);  add(0,LD,1,S_DECODE,O_DEC,1);
    add(0,LD,1,S_MEMADR,O_MAD,1);
    add(0,LD,0,S_MEMREAD,O_MRD,1); add(0,LD,0,S_MEMREAD,O_MRD,1);
    add(0,LD,0,S_MEMREAD,O_MRD,1); add(0,LD,1,S_MEMREAD,O_MRD,1);
    add(0,LD,1,S_MEMWB,O_MWB,1);
    // store with one wait cycle
    add(0,ST,1,S_FETCH,O_FR,2);  add(0,ST,1,S_DECODE,O_DEC,2);
    add(0,ST,1,S_MEMADR,O_MAD,2);
    add(0,ST,0,S_MEMWRITE,O_MWR,2); add(0,ST,1,S_MEMWRITE,O_MWR,2);
    // JALR
    add(0,JR,1,S_FETCH,O_FR,3);  add(0,JR,1,S_DECODE,O_DEC,3);
    add(0,JR,1,S_JALR,O_JLR,3);  add(0,JR,1,S_JAL,O_JAL,3);
    add(0,JR,1,S_ALUWB,O_AWB,3);
    // BEQ, I-type, AUIPC, LUI
    add(0,BR,1,S_FETCH,O_FR,4);  add(0,BR,1,S_DECODE,O_DEC,4);
    add(0,BR,1,S_BEQ,O_BEQ,4);
    add(0,I,1,S_FETCH,O_FR,5);   add(0,I,1,S_DECODE,O_DEC,5);
    add(0,I,1,S_EXECI,O_EXI,5);  add(0,I,1,S_ALUWB,O_AWB,5);
    add(0,AU,1,S_FETCH,O_FR,6);  add(0,AU,1,S_DECODE,O_DEC,6);
    add(0,AU,1,S_AUIPC,O_AUI,6); add(0,AU,1,S_ALUWB,O_AWB,6);
    add(0,LU,1,S_FETCH,O_FR,7);  add(0,LU,1,S_DECODE,O_DEC,7);
    add(0,LU,1,S_LUI,O_LUI,7);
    // counter at limit but ready arrives in the same cycle: fetch completes
    add(0,IL,0,S_FETCH,O_FN,8);  add(0,IL,0,S_FETCH,O_FN,8);
    add(0,IL,0,S_FETCH,O_FN,8);  add(0,IL,0,S_FETCH,O_FN,8);
    add(0,IL,1,S_FETCH,O_FR,8);
    // illegal opcode, then reset recovery
    add(0,IL,1,S_DECODE,O_DEC,8);
    add(0,IL,1,S_TRAP,O_TI,8);   add(0,IL,0,S_TRAP,O_TI,8);
    add(1,LD,1,S_FETCH,O_FN,0);
    // load timing out in MEMREAD
    add(0,LD,1,S_FETCH,O_FR,0);  add(0,LD,1,S_DECODE,O_DEC,0);
    add(0,LD,1,S_MEMADR,O_MAD,0);
    add(0,LD,0,S_MEMREAD,O_MRD,0); add(0,LD,0,S_MEMREAD,O_MRD,0);
    add(0,LD,0,S_MEMREAD,O_MRD,0); add(0,LD,0,S_MEMREAD,O_MRD,0);
    add(0,LD,0,S_MEMREAD,O_MRD,0);
    add(0,LD,1,S_TRAP,O_TT,0);   add(0,LD,1,S_TRAP,O_TT,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].op, vecs[i].rdy);
      chk($sformatf("vec%0d_state", i), state_o, vecs[i].st);
      chk($sformatf("vec%0d_outs", i), outs, vecs[i].outs);
      chk($sformatf("vec%0d_instret", i), instret, vecs[i].ret);
    end

    // fetch stuck waiting: trap after TIMEOUT_MAX+1 fetch cycles, then absorbing
    step(1,R,0);
    fc = 0;
    step(0,R,0);
    while (state_o == S_FETCH && fc < 20) begin
      fc++;
      step(0,R,0);
    end
    chk("timeout_fetch_cycles", fc, 5);
    chk("timeout_state", state_o, S_TRAP);
    for (int k = 0; k < 20; k++) begin
      step(0, 7'($urandom_range(0,127)), 1'($urandom_range(0,1)));
      chk($sformatf("trap_hold%0d", k), {state_o, trap, trap_cause, mem_req, pcupdate},
          {S_TRAP, 1'b1, 2'b10, 1'b0, 1'b0});
    end

    // sixteen LUIs wrap the 4-bit counter, then SYSTEM halts without retiring
    step(1,LU,1);
    for (int k = 0; k < 16; k++) begin
      step(0,LU,1);
      chk($sformatf("wrap_fetch%0d", k), {state_o, instret}, {S_FETCH, 4'(k)});
      step(0,LU,1);
      step(0,LU,1);
      chk($sformatf("wrap_lui%0d", k), state_o, S_LUI);
    end
    step(0,SY,1);
    chk("wrap_zero", {state_o, instret}, {S_FETCH, 4'd0});
    step(0,SY,1);
    step(0,SY,1);
    chk("halt_entry", {state_o, outs, instret}, {S_HALT, O_HLT, 4'd0});
    for (int k = 0; k < 3; k++) begin
      step(0,LU,1);
      chk($sformatf("halt_hold%0d", k), {state_o, halted, instret}, {S_HALT, 1'b1, 4'd0});
    end

    // asynchronous reset mid-wait clears the wait counter
    step(1,LD,1);
    step(0,LD,1);
    step(0,LD,1);
    step(0,LD,1);
    step(0,LD,0);
    step(0,LD,0);
    step(0,LD,0);
    chk("midwait_pre", state_o, S_MEMREAD);
    @(posedge clk);
    #2;
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("midwait_rst_state", {state_o, trap, halted, trap_cause, instret},
        {S_FETCH, 1'b0, 1'b0, 2'b00, 4'd0});
    chk("midwait_rst_outs", outs, O_FN);
    for (int k = 0; k < 5; k++) begin
      step(0,LD,0);
      chk($sformatf("midwait_fetch%0d", k), state_o, S_FETCH);
    end
    step(0,LD,0);
    chk("midwait_timeout", {state_o, trap_cause}, {S_TRAP, 2'b10});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
